// File: rtl/rvfi_ill_pkg.sv
// rtl/rvfi_ill_pkg.sv - shared types, illegal-class constants and classifier for the RVFI illegal-insn checker
package rvfi_ill_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PASS, ST_FAIL} state_t;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_NO_TRAP  = 3'd1,
    FC_RD_ADDR  = 3'd2,
    FC_RD_WDATA = 3'd3,
    FC_WMASK    = 3'd4,
    FC_BAD_PC   = 3'd5,
    FC_TIMEOUT  = 3'd6,
    FC_TRAP_VEC = 3'd7
  } fail_code_t;

  localparam int ILL_MODE_ZERO = 0;
  localparam int ILL_MODE_ONES = 1;
  localparam int ILL_MODE_RSVD = 2;

  localparam int ILEN_MAX = 64;
  localparam int N_RSVD   = 6;

  // Reserved major opcodes plus the long-encoding prefixes a 32-bit core cannot retire.
  localparam logic [6:0] RSVD_OPCODES [N_RSVD] = '{
    7'b1101011, 7'b1110111, 7'b0011111, 7'b1011111, 7'b0111111, 7'b1111111
  };

  function automatic logic is_illegal(input logic [ILEN_MAX-1:0] insn, input int ilen, input int mode);
    logic [ILEN_MAX-1:0] mask;
    logic                hit;
    mask = '1;
    if (ilen < ILEN_MAX) mask = ~('1 << ilen);
    hit = 1'b0;
    case (mode)
      ILL_MODE_ZERO: hit = ((insn & mask) == '0);
      ILL_MODE_ONES: hit = ((insn & mask) == mask);
      ILL_MODE_RSVD: for (int k = 0; k < N_RSVD; k++) if (insn[6:0] == RSVD_OPCODES[k]) hit = 1'b1;
      default:       hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/rvfi_ill_seq_check_if.sv
// rtl/rvfi_ill_seq_check_if.sv - RVFI retire bus bundle for the illegal-insn sequence checker
interface rvfi_ill_seq_check_if #(
  parameter int NRET = 1,
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic [NRET-1:0]        rvfi_valid;
  logic [NRET*64-1:0]     rvfi_order;
  logic [NRET*ILEN-1:0]   rvfi_insn;
  logic [NRET-1:0]        rvfi_trap;
  logic [NRET*5-1:0]      rvfi_rd_addr;
  logic [NRET*XLEN-1:0]   rvfi_rd_wdata;
  logic [NRET*XLEN-1:0]   rvfi_pc_rdata;
  logic [NRET*XLEN-1:0]   rvfi_pc_wdata;
  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_rd_addr,
           rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_wmask
  );
  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_rd_addr,
           rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_wmask
  );
endinterface

// File: rtl/rvfi_ill_match.sv
// rtl/rvfi_ill_match.sv - per-channel illegal-insn or successor-order match, lowest-index one-hot
module rvfi_ill_match
  import rvfi_ill_pkg::*;
#(
  parameter int NRET     = 1,
  parameter int ILEN     = 32,
  parameter int ILL_MODE = 0,
  parameter bit SUCC     = 1'b0
) (
  input  logic [NRET-1:0]      valid,
  input  logic [NRET-1:0]      mask,
  input  logic [NRET*ILEN-1:0] insn,
  input  logic [NRET*64-1:0]   order,
  input  logic [63:0]          exp_order,
  output logic [NRET-1:0]      onehot,
  output logic                 found
);
  logic [NRET-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NRET; i++) begin
      hit[i] = valid[i] && mask[i] &&
               (SUCC ? (order[i*64 +: 64] == exp_order)
                     : is_illegal(ILEN_MAX'(insn[i*ILEN +: ILEN]), ILEN, ILL_MODE));
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign onehot = hit & (~hit + 1'b1);
  assign found  = |hit;
endmodule

// File: rtl/rvfi_ill_seq_check.sv
// rtl/rvfi_ill_seq_check.sv - sequential illegal-insn checker; RISCV_FORMAL_ILL_MTVEC_EN adds trap_vec check
module rvfi_ill_seq_check
  import rvfi_ill_pkg::*;
#(
  parameter int NRET     = 1,
  parameter int XLEN     = 32,
  parameter int ILEN     = 32,
  parameter int ILL_MODE = 0,
  parameter int TIMEOUT  = 64
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 check,
`ifdef RISCV_FORMAL_ILL_MTVEC_EN
  input  logic [XLEN-1:0]      trap_vec,
`endif
  rvfi_ill_seq_check_if.slave  rvfi,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic [2:0]           fail_code
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int MW = XLEN / 8;

  state_t          state, state_nx;
  fail_code_t      code_q, code_nx, c_code;
  logic [63:0]     cap_order, cap_order_nx, c_order, exp_order;
  logic [XLEN-1:0] cap_pc, cap_pc_nx, c_pc_wdata, c_rd_wdata, s_pc_rdata, exp_pc;
  logic [TW-1:0]   timer, timer_nx;
  logic [4:0]      c_rd_addr;
  logic [MW-1:0]   c_wmask;
  logic            c_trap, cap_found, succ_found, seen;
  logic [NRET-1:0] cap_oh, succ_oh, succ_mask, all_ch;

  assign all_ch = '1;

  rvfi_ill_match #(.NRET(NRET), .ILEN(ILEN), .ILL_MODE(ILL_MODE), .SUCC(1'b0)) u_cap (
    .valid(rvfi.rvfi_valid), .mask(all_ch), .insn(rvfi.rvfi_insn), .order(rvfi.rvfi_order),
    .exp_order(exp_order), .onehot(cap_oh), .found(cap_found)
  );

  rvfi_ill_match #(.NRET(NRET), .ILEN(ILEN), .ILL_MODE(ILL_MODE), .SUCC(1'b1)) u_succ (
    .valid(rvfi.rvfi_valid), .mask(succ_mask), .insn(rvfi.rvfi_insn), .order(rvfi.rvfi_order),
    .exp_order(exp_order), .onehot(succ_oh), .found(succ_found)
  );

  // Field select for the captured and successor channels; only channels above the capture may succeed in the same cycle.
  always_comb begin
    c_order = '0; c_pc_wdata = '0; c_rd_wdata = '0; c_rd_addr = '0; c_wmask = '0; c_trap = 1'b0;
    s_pc_rdata = '0; seen = 1'b0; succ_mask = '0;
    for (int i = 0; i < NRET; i++) begin
      c_order    = c_order    | ({64{cap_oh[i]}}   & rvfi.rvfi_order[i*64 +: 64]);
      c_pc_wdata = c_pc_wdata | ({XLEN{cap_oh[i]}} & rvfi.rvfi_pc_wdata[i*XLEN +: XLEN]);
      c_rd_wdata = c_rd_wdata | ({XLEN{cap_oh[i]}} & rvfi.rvfi_rd_wdata[i*XLEN +: XLEN]);
      c_rd_addr  = c_rd_addr  | ({5{cap_oh[i]}}    & rvfi.rvfi_rd_addr[i*5 +: 5]);
      c_wmask    = c_wmask    | ({MW{cap_oh[i]}}   & rvfi.rvfi_mem_wmask[i*MW +: MW]);
      c_trap     = c_trap     | (cap_oh[i] & rvfi.rvfi_trap[i]);
      s_pc_rdata = s_pc_rdata | ({XLEN{succ_oh[i]}} & rvfi.rvfi_pc_rdata[i*XLEN +: XLEN]);
      succ_mask[i] = seen;
      seen = seen | cap_oh[i];
    end
    if (state != ST_IDLE) succ_mask = '1;
  end

  assign exp_order = ((state == ST_IDLE) ? c_order : cap_order) + 64'd1;
  assign exp_pc    = (state == ST_IDLE) ? c_pc_wdata : cap_pc;

  always_comb begin
    if (!c_trap)                 c_code = FC_NO_TRAP;
    else if (c_rd_addr != '0)    c_code = FC_RD_ADDR;
    else if (c_rd_wdata != '0)   c_code = FC_RD_WDATA;
    else if (c_wmask != '0)      c_code = FC_WMASK;
`ifdef RISCV_FORMAL_ILL_MTVEC_EN
    else if (c_pc_wdata != trap_vec) c_code = FC_TRAP_VEC;
`endif
    else                         c_code = FC_NONE;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      code_q    <= FC_NONE;
      cap_order <= '0;
      cap_pc    <= '0;
      timer     <= '0;
    end else begin
      state     <= state_nx;
      code_q    <= code_nx;
      cap_order <= cap_order_nx;
      cap_pc    <= cap_pc_nx;
      timer     <= timer_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    code_nx      = code_q;
    cap_order_nx = cap_order;
    cap_pc_nx    = cap_pc;
    timer_nx     = timer;
    case (state)
      ST_IDLE: if (check && cap_found) begin
        cap_order_nx = c_order;
        cap_pc_nx    = c_pc_wdata;
        timer_nx     = '0;
        if (c_code != FC_NONE) begin
          state_nx = ST_FAIL;
          code_nx  = c_code;
        end else if (succ_found) begin
          state_nx = (s_pc_rdata == exp_pc) ? ST_PASS : ST_FAIL;
          if (s_pc_rdata != exp_pc) code_nx = FC_BAD_PC;
        end else begin
          state_nx = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (timer != {TW{1'b1}}) timer_nx = timer + 1'b1;
        // A successor in the final cycle beats the timeout.
        if (succ_found) begin
          state_nx = (s_pc_rdata == exp_pc) ? ST_PASS : ST_FAIL;
          if (s_pc_rdata != exp_pc) code_nx = FC_BAD_PC;
        end else if ((TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1))) begin
          state_nx = ST_FAIL;
          code_nx  = FC_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state == ST_ARMED);
    pass      = (state == ST_PASS);
    fail      = (state == ST_FAIL);
    fail_code = code_q;
  end

`ifdef FORMAL
  always @(posedge clock) begin
    if (resetn) begin
      cover (pass);
      assert (!fail);
    end
  end
`endif
endmodule
